// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the OTTER IOBUS: stores to DATA_AD
// are queued in a FIFO and shifted out LSB first; STAT_AD reports busy/full/overflow.
module iobus_uart_tx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] DATA_AD    = 32'h11000060,
  parameter logic [31:0] STAT_AD    = 32'h11000064
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        TX
);

  localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            full_s, empty_s, wr_data_s, wr_stat_s, push_s, pop_s, ovf_set_s;
  logic            baud_end_s;
  logic [31:0]     stat_s;
  logic            unused_s;

  assign unused_s = ^IOBUS_OUT[31:8];

  // Bus decode and FIFO occupancy flags from the registered count
  always_comb begin
    full_s     = (cnt_q == DEPTH_C);
    empty_s    = (cnt_q == {CW{1'b0}});
    wr_data_s  = IOBUS_WR && (IOBUS_ADDR == DATA_AD);
    wr_stat_s  = IOBUS_WR && (IOBUS_ADDR == STAT_AD);
    push_s     = wr_data_s && !full_s;
    ovf_set_s  = wr_data_s && full_s;
    baud_end_s = (baud_q == BAUD_LAST);
  end

  // Frame sequencer: next state, baud/bit counters, shift register, line level
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = {BW{1'b0}};
        bit_d  = 3'd0;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          baud_d  = {BW{1'b0}};
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_d  = {BW{1'b0}};
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          baud_d = {BW{1'b0}};
          // Chain the next frame directly so there is no idle bit between bytes
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = {BW{1'b0}};
        bit_d   = 3'd0;
      end
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy count and sticky overflow flag
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (wr_stat_s && IOBUS_OUT[2]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Status word for the wrapper input mux
  always_comb begin
    stat_s = {15'd0, 9'(cnt_q), 4'd0, empty_s, ovf_q, full_s,
              (state_q != S_IDLE) || !empty_s};
    if (IOBUS_ADDR == STAT_AD) begin
      RD_DATA = stat_s;
    end else begin
      RD_DATA = 32'h0000_0000;
    end
  end

  // Control state; reset idles the line high at once
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      baud_q   <= {BW{1'b0}};
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      cnt_q    <= {CW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; stale entries are unreachable once the count is cleared
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= IOBUS_OUT[7:0];
    end
  end

  assign TX = tx_q;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Randomised scoreboard bench for iobus_uart_tx: a queue/timing model predicts
// frame contents, start cycles and the status word; a line monitor checks TX.
module tb_iobus_uart_tx;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int FRAME  = 10 * DIV;
  localparam logic [31:0] DATA_AD = 32'h11000060;
  localparam logic [31:0] STAT_AD = 32'h11000064;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] IOBUS_ADDR = 32'h0;
  logic [31:0] IOBUS_OUT = 32'h0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] RD_DATA;
  logic        TX;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct { logic [7:0] b; int t; } exp_t;
  logic [7:0] mq[$];
  exp_t       exp_q[$];
  int         free_at = 0;
  bit         ovf_m = 1'b0;

  iobus_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
                  .DATA_AD(DATA_AD), .STAT_AD(STAT_AD)) dut (
    .CLK(CLK), .RST_N(RST_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .RD_DATA(RD_DATA), .TX(TX));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_stat();
    int n;
    logic busy;
    n = mq.size();
    busy = (cyc < free_at) || (n != 0);
    return {15'd0, 9'(n), 4'd0, (n == 0), ovf_m, (n == DEPTH), busy};
  endfunction

  // Reference model: a single server with a FRAME-cycle service time and a DEPTH-slot queue
  always @(posedge CLK) begin
    int n;
    exp_t e;
    cyc = cyc + 1;
    if (!RST_N) begin
      mq.delete();
      exp_q.delete();
      free_at = 0;
      ovf_m = 1'b0;
    end else begin
      n = mq.size();
      if (n != 0 && cyc >= free_at) begin
        e.b = mq.pop_front();
        e.t = cyc;
        exp_q.push_back(e);
        free_at = cyc + FRAME;
      end
      if (IOBUS_WR && IOBUS_ADDR == DATA_AD) begin
        if (n == DEPTH) ovf_m = 1'b1;
        else mq.push_back(IOBUS_OUT[7:0]);
      end else if (IOBUS_WR && IOBUS_ADDR == STAT_AD && IOBUS_OUT[2]) begin
        ovf_m = 1'b0;
      end
    end
  end

  // Line monitor: finds start edges and samples every bit mid-period
  bit         in_frame = 1'b0;
  bit         prev_tx = 1'b1;
  int         t0 = 0;
  logic [7:0] got = 8'h00;
  always @(negedge CLK) begin
    int off, k;
    exp_t e;
    if (!RST_N) begin
      in_frame = 1'b0;
      prev_tx = 1'b1;
    end else begin
      if (!in_frame) begin
        if (prev_tx && !TX) begin
          in_frame = 1'b1;
          t0 = cyc;
          if (exp_q.size() == 0) begin
            check("spurious_frame", 32'(t0), 32'hFFFF_FFFF);
          end else begin
            check("start_cycle", 32'(t0), 32'(exp_q[0].t));
          end
        end
      end else begin
        off = cyc - t0;
        if (off % DIV == DIV / 2) begin
          k = off / DIV;
          if (k == 0) begin
            check("start_bit", {31'd0, TX}, 32'd0);
          end else if (k <= 8) begin
            got[k-1] = TX;
          end else begin
            check("stop_bit", {31'd0, TX}, 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("frame_byte", {24'd0, got}, {24'd0, e.b});
            end
            in_frame = 1'b0;
          end
        end
      end
      prev_tx = TX;
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge CLK);
    IOBUS_ADDR = addr;
    IOBUS_OUT = data;
    IOBUS_WR = 1'b1;
  endtask

  task automatic bus_idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      IOBUS_WR = 1'b0;
      IOBUS_ADDR = 32'h0;
      IOBUS_OUT = 32'h0;
    end
  endtask

  task automatic read_check(input string name, input logic [31:0] addr);
    @(negedge CLK);
    IOBUS_WR = 1'b0;
    IOBUS_ADDR = addr;
    #1;
    check(name, RD_DATA, (addr == STAT_AD) ? model_stat() : 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    bit drained;
    // Reset and idle state
    bus_idle(5);
    #1;
    check("tx_in_reset", {31'd0, TX}, 32'd1);
    RST_N = 1'b1;
    read_check("reset_stat", STAT_AD);
    check("reset_stat_const", RD_DATA, 32'h0000_0008);

    // Single byte
    bus_write(DATA_AD, 32'h0000_00A5);
    read_check("single_stat0", STAT_AD);
    bus_idle(50);
    read_check("single_stat_mid", STAT_AD);
    bus_idle(55);
    read_check("single_stat_end", STAT_AD);
    check("single_end_const", RD_DATA, 32'h0000_0008);

    // Back-to-back frames
    bus_write(DATA_AD, 32'h0000_0055);
    bus_write(DATA_AD, 32'h0000_000F);
    read_check("b2b_stat_cnt1", STAT_AD);
    check("b2b_cnt1_const", RD_DATA, 32'h0000_0101);
    bus_idle(110);
    read_check("b2b_stat_cnt0", STAT_AD);
    bus_idle(100);

    // Overflow with a 4-deep FIFO
    for (int i = 0; i < 6; i++) bus_write(DATA_AD, 32'h10 + 32'(i) + 32'h1);
    read_check("ovf_stat", STAT_AD);
    check("ovf_stat_const", RD_DATA, 32'h0000_0407);
    bus_write(STAT_AD, 32'h0000_0004);
    read_check("ovf_clear_stat", STAT_AD);
    check("ovf_clear_const", RD_DATA, 32'h0000_0403);
    bus_idle(520);
    read_check("ovf_drain_stat", STAT_AD);

    // Address isolation
    bus_write(32'h1100_0020, 32'h0000_005A);
    read_check("iso_read", 32'h1100_0000);
    check("iso_read_const", RD_DATA, 32'h0);
    bus_idle(20);
    check("iso_tx", {31'd0, TX}, 32'd1);

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 15))
        0: repeat ($urandom_range(1, 6)) bus_write(DATA_AD, $urandom);
        1: bus_write(DATA_AD, $urandom);
        2: bus_write(STAT_AD, $urandom);
        3: bus_write(32'h1100_0068, $urandom);
        4, 5, 6, 7: read_check("rand_stat", STAT_AD);
        8: begin
          ra = ($urandom_range(0, 1) == 0) ? DATA_AD : 32'h1100_0020;
          read_check("rand_other_rd", ra);
        end
        default: bus_idle($urandom_range(1, 40));
      endcase
    end
    bus_idle(1);
    drained = 1'b0;
    for (int w = 0; w < 1500 && !drained; w++) begin
      @(negedge CLK);
      drained = (exp_q.size() == 0) && (mq.size() == 0) && (cyc >= free_at) && !in_frame;
    end
    check("drain_done", {31'd0, drained}, 32'd1);
    read_check("drain_stat", STAT_AD);

    // Reset in the middle of a frame
    bus_write(DATA_AD, 32'h0000_0000);
    bus_idle(30);
    check("midframe_tx_low", {31'd0, TX}, 32'd0);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset_tx", {31'd0, TX}, 32'd1);
    bus_idle(3);
    RST_N = 1'b1;
    read_check("post_reset_stat", STAT_AD);
    check("post_reset_const", RD_DATA, 32'h0000_0008);
    bus_idle(150);
    check("post_reset_tx", {31'd0, TX}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iobus_uart_tx.md
Name: iobus_uart_tx

Overview:
- Memory-mapped UART transmitter on the OTTER IOBUS, downstream of the wrapper's IOBUS output decode.
- Consumes CPU stores to its data address, buffers bytes in a FIFO, and serialises them 8N1, LSB first, on TX.
- Provides a status word for the wrapper's IOBUS input mux, so firmware can poll busy, full and overflow.
- Runs on the 50 MHz processor clock.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate. DIV = (CLK_HZ + BAUD/2) / BAUD, integer; 434 at the defaults. DIV must be >= 2.
- FIFO_DEPTH, 16, transmit FIFO depth in bytes; power of 2, 2..256.
- DATA_AD, 32'h11000060, write address for the data register.
- STAT_AD, 32'h11000064, read/write address for the status register.

Ports:
- CLK  in  1  processor clock (clk_50 domain).
- RST_N  in  1  reset; asynchronous, active-low.
- IOBUS_ADDR  in  32  bus address from the CPU.
- IOBUS_OUT  in  32  store data from the CPU.
- IOBUS_WR  in  1  store strobe, one cycle per store.
- RD_DATA  out  32  status word to the wrapper input mux (combinational).
- TX  out  1  serial line; idles high.

Behaviour:
- Reset (asynchronous, while RST_N=0):
  - TX=1, FSM in IDLE, FIFO empty (count=0), OVF=0, baud and bit counters 0.
  - Reset mid-frame aborts the frame; TX returns to 1 immediately, without waiting for a clock edge.
  - FIFO contents are discarded.
- Write decode:
  - IOBUS_WR=1 and IOBUS_ADDR==DATA_AD: push IOBUS_OUT[7:0] if count<FIFO_DEPTH.
  - Same write when count==FIFO_DEPTH: byte dropped, OVF set (sticky).
  - Fullness is judged on the registered count. A push while full is dropped even if a pop happens in the same cycle.
  - IOBUS_WR=1 and IOBUS_ADDR==STAT_AD with IOBUS_OUT[2]=1: clears OVF. If an overflow occurs in the same cycle as the clear, set wins.
  - Writes to any other address are ignored.
- RD_DATA:
  - Equals STAT when IOBUS_ADDR==STAT_AD, otherwise 32'h0.
  - STAT layout: [0] BUSY = (state!=IDLE) or (count!=0); [1] FULL = (count==FIFO_DEPTH); [2] OVF; [3] EMPTY = (count==0); [16:8] count; all other bits 0.
- FIFO:
  - Circular buffer with read/write pointers mod FIFO_DEPTH and a separate count register of width $clog2(FIFO_DEPTH)+1.
  - Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If count!=0, pop the head byte into an 8-bit shift register, clear the baud counter and go to START at that edge.
  - START: TX=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: TX=shift[0] for DIV cycles per bit, shifting right after each bit. After bit 7, go to STOP.
  - STOP: TX=1 for DIV cycles.
    - At the end, if count!=0: pop and go straight to START (back-to-back frames, no extra idle bit).
    - Otherwise go to IDLE.
- TX is driven from a register, never combinationally.
- Frame length is exactly 10*DIV cycles.
- Latency: a push at edge N into an empty FIFO with the FSM idle gives a pop at edge N+1; TX falls after edge N+1.
- The baud counter runs 0..DIV-1 and wraps; the bit boundary is at DIV-1.
- Byte order on the line is FIFO order, with no loss unless OVF is reported.

Test Plan:
- Reset/idle: hold RST_N=0, then release. Expect TX=1, STAT read = 32'h00000008 (EMPTY), BUSY=0.
- Single byte (CLK_HZ=1000, BAUD=100, so DIV=10): write 32'h000000A5 to DATA_AD.
  - TX falls 2 edges after the write and sends bits 0,1,0,1,0,0,1,0,1,1 (LSB first), each 10 cycles.
  - BUSY=1 throughout; BUSY drops 100 cycles after the first TX low.
- Back-to-back: write 8'h55 then 8'h0F on consecutive cycles. Expect two contiguous 100-cycle frames with no idle gap, and count goes 1 then 0.
- Overflow: with DIV=10 and FIFO_DEPTH=4, write 6 bytes on consecutive cycles.
  - First byte is popped immediately, 4 are buffered, the 6th is dropped.
  - STAT shows FULL=1, OVF=1, count=4.
  - Write 32'h4 to STAT_AD: OVF reads 0, and the 5 accepted bytes appear on TX in order.
- Mid-frame reset: assert RST_N=0 during the DATA state of byte 8'h00. Expect TX=1 within the same cycle (asynchronous), STAT=32'h8 after release, and no further frame.
- Address isolation: write to 32'h11000020 and read 32'h11000000. Expect TX stays 1 and RD_DATA=0.
